// File: rtl/grid_cursor_ctrl.sv
// Grid cursor controller: moves a tile cursor with debounced direction
// buttons (single step on press, auto-repeat while held), issues a select
// pulse on each centre press, counts accepted selects, and freezes while the
// puzzle is solved.
// Ports:
//   clk_1khz, reset            - clock, synchronous active-high reset
//   pbUp/pbDown/pbLeft/pbRight - direction buttons (level)
//   pbCenter                   - select button (level)
//   solved                     - freeze request
//   col, row                   - cursor tile indices
//   selector_x, selector_y     - cursor pixel position
//   select_pulse               - one-cycle toggle request
//   move_count                 - saturating count of selects
//   locked                     - high while frozen
module grid_cursor_ctrl #(
  parameter int unsigned GRID_COLS  = 4,
  parameter int unsigned GRID_ROWS  = 4,
  parameter int unsigned X0         = 8,
  parameter int unsigned Y0         = 4,
  parameter int unsigned PITCH_X    = 20,
  parameter int unsigned PITCH_Y    = 15,
  parameter int unsigned REPEAT_DLY = 300,
  parameter int unsigned REPEAT_INT = 100
) (
  input  logic       clk_1khz,
  input  logic       reset,
  input  logic       pbUp,
  input  logic       pbDown,
  input  logic       pbLeft,
  input  logic       pbRight,
  input  logic       pbCenter,
  input  logic       solved,
  output logic [2:0] col,
  output logic [2:0] row,
  output logic [6:0] selector_x,
  output logic [5:0] selector_y,
  output logic       select_pulse,
  output logic [7:0] move_count,
  output logic       locked
);

  localparam int unsigned CNT_MAX = (REPEAT_DLY > REPEAT_INT) ? REPEAT_DLY : REPEAT_INT;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCKED} state_e;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;

  state_e           state_q, state_d;
  dir_e             dir_q, dir_d, step_dir;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       dir_hist_q, dir_hist_d;
  logic             ctr_hist_q, ctr_hist_d;
  logic [2:0]       col_q, col_d, row_q, row_d;
  logic [6:0]       sel_x_q, sel_x_d;
  logic [5:0]       sel_y_q, sel_y_d;
  logic             pulse_q, pulse_d;
  logic [7:0]       mcount_q, mcount_d;
  logic             locked_q, locked_d;
  logic             step;

  logic [3:0] dir_btn, dir_edge;
  logic       ctr_edge, held;

  // Bit order doubles as priority: lowest index wins.
  assign dir_btn  = {pbRight, pbLeft, pbDown, pbUp};
  assign dir_edge = dir_btn & ~dir_hist_q;
  assign ctr_edge = pbCenter & ~ctr_hist_q;
  assign held     = dir_btn[dir_q];

  function automatic dir_e pick_dir(input logic [3:0] e);
    if (e[0])      return DIR_UP;
    else if (e[1]) return DIR_DOWN;
    else if (e[2]) return DIR_LEFT;
    else           return DIR_RIGHT;
  endfunction

  // State, edge history and select handling.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    step       = 1'b0;
    step_dir   = dir_q;
    dir_hist_d = dir_btn;
    ctr_hist_d = pbCenter;
    pulse_d    = 1'b0;
    mcount_d   = mcount_q;

    if (solved || state_q == LOCKED) begin
      // Frozen: buttons held now must be released before they count again.
      dir_hist_d = dir_hist_q | dir_btn;
      ctr_hist_d = ctr_hist_q | pbCenter;
      state_d    = solved ? LOCKED : IDLE;
    end else begin
      pulse_d = ctr_edge;
      if (ctr_edge && mcount_q != 8'hFF) mcount_d = mcount_q + 8'd1;

      case (state_q)
        IDLE: begin
          if (|dir_edge) begin
            step     = 1'b1;
            step_dir = pick_dir(dir_edge);
            dir_d    = step_dir;
            cnt_d    = '0;
            state_d  = HOLD;
          end
        end
        HOLD, REPEAT: begin
          // History only clears here, so a direction pressed while tracking
          // another is still seen as an edge once back in IDLE.
          dir_hist_d = dir_hist_q & dir_btn;
          if (!held) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else if ((state_q == HOLD   && cnt_q == CNT_W'(REPEAT_DLY - 1)) ||
                       (state_q == REPEAT && cnt_q == CNT_W'(REPEAT_INT - 1))) begin
            step    = 1'b1;
            cnt_d   = '0;
            state_d = REPEAT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  // Cursor movement with wrap-around and pixel position.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (step) begin
      case (step_dir)
        DIR_UP:    row_d = (row_q == 3'd0) ? 3'(GRID_ROWS - 1) : row_q - 3'd1;
        DIR_DOWN:  row_d = (row_q == 3'(GRID_ROWS - 1)) ? 3'd0 : row_q + 3'd1;
        DIR_LEFT:  col_d = (col_q == 3'd0) ? 3'(GRID_COLS - 1) : col_q - 3'd1;
        default:   col_d = (col_q == 3'(GRID_COLS - 1)) ? 3'd0 : col_q + 3'd1;
      endcase
    end
    sel_x_d = 7'(X0 + PITCH_X * 32'(col_d));
    sel_y_d = 6'(Y0 + PITCH_Y * 32'(row_d));
  end

  always_ff @(posedge clk_1khz) begin
    if (reset) begin
      state_q    <= IDLE;
      dir_q      <= DIR_UP;
      cnt_q      <= '0;
      dir_hist_q <= '1;
      ctr_hist_q <= 1'b1;
      col_q      <= '0;
      row_q      <= '0;
      sel_x_q    <= 7'(X0);
      sel_y_q    <= 6'(Y0);
      pulse_q    <= 1'b0;
      mcount_q   <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      dir_hist_q <= dir_hist_d;
      ctr_hist_q <= ctr_hist_d;
      col_q      <= col_d;
      row_q      <= row_d;
      sel_x_q    <= sel_x_d;
      sel_y_q    <= sel_y_d;
      pulse_q    <= pulse_d;
      mcount_q   <= mcount_d;
      locked_q   <= locked_d;
    end
  end

  assign col          = col_q;
  assign row          = row_q;
  assign selector_x   = sel_x_q;
  assign selector_y   = sel_y_q;
  assign select_pulse = pulse_q;
  assign move_count   = mcount_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// Bench for grid_cursor_ctrl: time-based behavioural model checked every
// cycle, plus hand-computed expectations along a directed scenario.
module tb_grid_cursor_ctrl;

  localparam int COLS = 4, ROWS = 4, X0 = 8, Y0 = 4, PX = 20, PY = 15;
  localparam int DLY = 300, INTV = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pbUp = 0, pbDown = 0, pbLeft = 0, pbRight = 0, pbCenter = 0, solved = 0;
  logic [2:0] col, row;
  logic [6:0] selector_x;
  logic [5:0] selector_y;
  logic       select_pulse, locked;
  logic [7:0] move_count;

  int checks = 0;
  int errors = 0;
  int pulses_seen = 0;

  grid_cursor_ctrl #(
    .GRID_COLS(COLS), .GRID_ROWS(ROWS), .X0(X0), .Y0(Y0),
    .PITCH_X(PX), .PITCH_Y(PY), .REPEAT_DLY(DLY), .REPEAT_INT(INTV)
  ) dut (
    .clk_1khz(clk), .reset(reset),
    .pbUp(pbUp), .pbDown(pbDown), .pbLeft(pbLeft), .pbRight(pbRight),
    .pbCenter(pbCenter), .solved(solved),
    .col(col), .row(row), .selector_x(selector_x), .selector_y(selector_y),
    .select_pulse(select_pulse), .move_count(move_count), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A press counts only if the button has been seen released while the
  // cursor was free. Steps happen at press time, press+DLY, and every INTV
  // after that while the same button stays held.
  int  m_col, m_row, m_count, m_t, press_t, trk;
  bit  m_pulse, m_locked, tracking, model_valid;
  bit  armed[4];
  bit  armed_c;

  task automatic move(input int d);
    case (d)
      0: m_row = (m_row + ROWS - 1) % ROWS;
      1: m_row = (m_row + 1) % ROWS;
      2: m_col = (m_col + COLS - 1) % COLS;
      default: m_col = (m_col + 1) % COLS;
    endcase
  endtask

  always @(posedge clk) begin
    bit bt[4];
    int w, el;
    bt[0] = pbUp; bt[1] = pbDown; bt[2] = pbLeft; bt[3] = pbRight;
    m_t++;
    if (reset) begin
      m_col = 0; m_row = 0; m_count = 0; m_pulse = 0; m_locked = 0;
      tracking = 0; armed_c = 0;
      for (int i = 0; i < 4; i++) armed[i] = 0;
      model_valid = 1;
    end else if (solved || m_locked) begin
      m_pulse = 0;
      for (int i = 0; i < 4; i++) armed[i] = armed[i] && !bt[i];
      armed_c  = armed_c && !pbCenter;
      m_locked = solved;
      tracking = 0;
    end else begin
      m_pulse = pbCenter && armed_c;
      if (m_pulse && m_count < 255) m_count++;
      armed_c = !pbCenter;
      if (!tracking) begin
        w = -1;
        for (int i = 3; i >= 0; i--) if (bt[i] && armed[i]) w = i;
        if (w >= 0) begin
          move(w);
          tracking = 1; trk = w; press_t = m_t;
        end
        for (int i = 0; i < 4; i++) armed[i] = !bt[i];
      end else begin
        if (!bt[trk]) tracking = 0;
        else begin
          el = m_t - press_t;
          if (el == DLY || (el > DLY && (el - DLY) % INTV == 0)) move(trk);
        end
        for (int i = 0; i < 4; i++) armed[i] = armed[i] || !bt[i];
      end
    end
  end

  // Per-cycle comparison, after outputs settle.
  always @(posedge clk) begin
    #1;
    if (select_pulse === 1'b1) pulses_seen++;
    if (model_valid) begin
      chk("col",          int'(col),          m_col);
      chk("row",          int'(row),          m_row);
      chk("selector_x",   int'(selector_x),   X0 + m_col * PX);
      chk("selector_y",   int'(selector_y),   Y0 + m_row * PY);
      chk("select_pulse", int'(select_pulse), int'(m_pulse));
      chk("move_count",   int'(move_count),   m_count);
      chk("locked",       int'(locked),       int'(m_locked));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tap_right();
    pbRight = 1; tick(1); pbRight = 0; tick(2);
  endtask

  initial begin
    int p0;
    tick(3);
    reset = 0;
    tick(2);
    chk("rst_col", int'(col), 0);
    chk("rst_row", int'(row), 0);
    chk("rst_selx", int'(selector_x), 8);
    chk("rst_sely", int'(selector_y), 4);
    chk("rst_cnt", int'(move_count), 0);
    chk("rst_locked", int'(locked), 0);

    // Single step right.
    pbRight = 1; tick(1);
    chk("r1_col", int'(col), 1);
    chk("r1_selx", int'(selector_x), 28);
    pbRight = 0; tick(2);
    chk("r1_nopulse", pulses_seen, 0);

    // Column and row wrap.
    tap_right(); tap_right();
    chk("col3", int'(col), 3);
    tap_right();
    chk("wrap_col", int'(col), 0);
    chk("wrap_selx", int'(selector_x), 8);
    pbUp = 1; tick(1); pbUp = 0; tick(2);
    chk("wrap_row", int'(row), 3);
    chk("wrap_sely", int'(selector_y), 49);

    // Auto-repeat: steps at edge, +300, +400, +500, +600.
    pbDown = 1; tick(1); pbDown = 0; tick(2);
    chk("down_row0", int'(row), 0);
    pbDown = 1;
    tick(1);   chk("rep_1", int'(row), 1);
    tick(299); chk("rep_299", int'(row), 1);
    tick(1);   chk("rep_300", int'(row), 2);
    tick(99);  chk("rep_399", int'(row), 2);
    tick(1);   chk("rep_400", int'(row), 3);
    tick(100); chk("rep_500", int'(row), 0);
    tick(100); chk("rep_600", int'(row), 1);
    tick(99);
    pbDown = 0; tick(2);
    chk("rep_end", int'(row), 1);

    // Release during HOLD: no further step.
    pbLeft = 1; tick(1); tick(50); pbLeft = 0; tick(300);
    chk("hold_rel_col", int'(col), 3);

    // Another direction pressed while tracking fires after release.
    pbLeft = 1; tick(11);
    pbDown = 1; tick(5);
    chk("meanwhile_row", int'(row), 1);
    pbLeft = 0; tick(1);
    chk("meanwhile_row_b", int'(row), 1);
    tick(1);
    chk("meanwhile_row_c", int'(row), 2);
    chk("meanwhile_col", int'(col), 2);
    pbDown = 0; tick(2);

    // Simultaneous edges resolve by priority.
    pbDown = 1; pbRight = 1; tick(1); pbDown = 0; pbRight = 0; tick(2);
    chk("prio_dr_row", int'(row), 3);
    chk("prio_dr_col", int'(col), 2);
    pbUp = 1; pbLeft = 1; tick(1); pbUp = 0; pbLeft = 0; tick(2);
    chk("prio_ul_row", int'(row), 2);
    chk("prio_ul_col", int'(col), 2);

    // 300 selects saturate the counter at 255.
    p0 = pulses_seen;
    for (int i = 0; i < 300; i++) begin
      pbCenter = 1; tick(1); pbCenter = 0; tick(1);
    end
    chk("sel_pulses", pulses_seen - p0, 300);
    chk("sel_sat", int'(move_count), 255);

    // Lock: everything ignored.
    solved = 1; tick(1);
    chk("lock_on", int'(locked), 1);
    p0 = pulses_seen;
    {pbUp, pbDown, pbLeft, pbRight, pbCenter} = 5'b11111; tick(1);
    {pbUp, pbDown, pbLeft, pbRight, pbCenter} = 5'b00000; tick(1);
    chk("lock_col", int'(col), 2);
    chk("lock_row", int'(row), 2);
    chk("lock_cnt", int'(move_count), 255);
    chk("lock_nopulse", pulses_seen - p0, 0);
    pbCenter = 1; pbRight = 1; tick(1);
    solved = 0; tick(3);
    chk("unlock", int'(locked), 0);
    chk("unlock_nopulse", pulses_seen - p0, 0);
    chk("unlock_col", int'(col), 2);
    pbCenter = 0; pbRight = 0; tick(2);
    pbCenter = 1; pbRight = 1; tick(1);
    chk("repress_pulse", pulses_seen - p0, 1);
    chk("repress_col", int'(col), 3);
    pbCenter = 0; pbRight = 0; tick(2);

    // Reset mid-REPEAT with the button still held.
    pbRight = 1; tick(350);
    chk("pre_rst_col", int'(col), 1);
    reset = 1; tick(1);
    chk("mid_rst_col", int'(col), 0);
    chk("mid_rst_cnt", int'(move_count), 0);
    reset = 0; tick(200);
    chk("held_after_rst", int'(col), 0);
    pbRight = 0; tick(2);
    pbRight = 1; tick(1);
    chk("rst_repress_col", int'(col), 1);
    chk("rst_repress_selx", int'(selector_x), 28);
    pbRight = 0; tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
